// File: rtl/systolic_array_load_sequencer.sv
// ---------------------------------------------------------------------------
// systolic_array_load_sequencer
//
// Memory-side driver for the systolic array load port. One `start` sequences
// one tile: N weight rows, then N input rows interleaved with N partial-sum
// rows (I0,P0,I1,P1,...). Row beats arrive from an upstream source over a
// valid/ready handshake and are re-issued, registered, on the array bus.
//
// Optional feature macro: SEQ_WEIGHT_REUSE_EN
//   defined   : reuse_weights=1 in the start cycle skips the weight phase and
//               the tile goes straight to LOAD_I (2N beats).
//   undefined : reuse_weights is ignored; every tile runs LOAD_W (3N beats).
//
// Handshake: a beat transfers on a rising edge where src_valid && src_ready.
//   src_ready depends only on the FSM state and fifo_has_space, never on
//   src_valid. The source must hold src_data stable while src_valid is high
//   and no transfer has happened.
//
// Parameters:
//   N   array dimension (rows per phase), power of two, >= 2
//   DW  element width; a row is N*DW bits
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   start          one-cycle tile request, sampled only in IDLE
//   reuse_weights  skip the weight phase (feature macro only)
//   src_valid      upstream beat valid
//   src_data       upstream row beat (N*DW)
//   src_ready      sequencer accepts a beat this cycle
//   fifo_has_space array FIFOs can take an input/partial row
//   weight_en      array bus carries a weight row
//   input_en       array bus carries an input row
//   partial_en     array bus carries a partial-sum row
//   row_in_en      row index of the last weight/input beat
//   row_ps_en      row index of the last partial beat
//   array_data     row data to the array (holds last beat)
//   busy           tile in progress (LOAD_W/LOAD_I/LOAD_P)
//   done           one-cycle pulse once the tile is fully issued
//   fsm_state      current FSM state, for observation
// ---------------------------------------------------------------------------
module systolic_array_load_sequencer #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    reuse_weights,
  input  logic                    src_valid,
  input  logic [N*DW-1:0]         src_data,
  output logic                    src_ready,
  input  logic                    fifo_has_space,
  output logic                    weight_en,
  output logic                    input_en,
  output logic                    partial_en,
  output logic [$clog2(N)-1:0]    row_in_en,
  output logic [$clog2(N)-1:0]    row_ps_en,
  output logic [N*DW-1:0]         array_data,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              fsm_state
);

  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] R_LAST = RW'(N - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_LOAD_I = 3'd2;
  localparam logic [2:0] S_LOAD_P = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [RW-1:0] r;
  logic [RW-1:0] r_nxt;
  logic          accept;
  logic          skip_weights;

`ifdef SEQ_WEIGHT_REUSE_EN
  assign skip_weights = reuse_weights;
`else
  // Port kept for a stable interface; its value has no effect here.
  logic unused_reuse_weights;
  assign unused_reuse_weights = reuse_weights;
  assign skip_weights         = 1'b0;
`endif

  // Weights go straight into the MAC registers, so only the input and
  // partial phases are throttled by the array FIFOs.
  always_comb begin
    src_ready = 1'b0;
    case (state)
      S_LOAD_W: src_ready = 1'b1;
      S_LOAD_I: src_ready = fifo_has_space;
      S_LOAD_P: src_ready = fifo_has_space;
      default:  src_ready = 1'b0;
    endcase
  end

  assign accept = src_valid && src_ready;

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    case (state)
      S_IDLE: begin
        if (start) begin
          r_nxt     = '0;
          state_nxt = skip_weights ? S_LOAD_I : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (accept) begin
          // The phase change absorbs the wrap: r restarts for the I/P phase.
          if (r == R_LAST) begin
            r_nxt     = '0;
            state_nxt = S_LOAD_I;
          end else begin
            r_nxt = r + RW'(1);
          end
        end
      end
      S_LOAD_I: begin
        // The same r is reused by the following partial beat.
        if (accept) begin
          state_nxt = S_LOAD_P;
        end
      end
      S_LOAD_P: begin
        if (accept) begin
          if (r == R_LAST) begin
            r_nxt     = '0;
            state_nxt = S_DONE;
          end else begin
            r_nxt     = r + RW'(1);
            state_nxt = S_LOAD_I;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        r_nxt     = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      r     <= '0;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
    end
  end

  // Array-side outputs are registered: a beat accepted on edge k is shown
  // for exactly the cycle after edge k. Data and row indices hold between
  // beats so the array sees a stable bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_en  <= 1'b0;
      input_en   <= 1'b0;
      partial_en <= 1'b0;
      row_in_en  <= '0;
      row_ps_en  <= '0;
      array_data <= '0;
    end else begin
      weight_en  <= accept && (state == S_LOAD_W);
      input_en   <= accept && (state == S_LOAD_I);
      partial_en <= accept && (state == S_LOAD_P);
      if (accept) begin
        array_data <= src_data;
        if (state == S_LOAD_P) begin
          row_ps_en <= r;
        end else begin
          row_in_en <= r;
        end
      end
    end
  end

  assign busy      = (state == S_LOAD_W) || (state == S_LOAD_I) ||
                     (state == S_LOAD_P);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_systolic_array_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_systolic_array_load_sequencer
//
// Directed bench for systolic_array_load_sequencer with N=4, DW=16.
// A source driver feeds numbered row beats; each tile pushes its expected
// array-bus beats (kind, row, data) into exp_q, and a negedge monitor pops
// and compares every issued beat. Tile latency, stall behaviour, aborts and
// ignored starts are checked from the main sequence.
// ---------------------------------------------------------------------------
module tb_systolic_array_load_sequencer;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int W  = N * DW;

  localparam logic [1:0] K_W = 2'd1;
  localparam logic [1:0] K_I = 2'd2;
  localparam logic [1:0] K_P = 2'd3;

  logic         clk;
  logic         rst;
  logic         start;
  logic         reuse_weights;
  logic         src_valid;
  logic [W-1:0] src_data;
  logic         src_ready;
  logic         fifo_has_space;
  logic         weight_en;
  logic         input_en;
  logic         partial_en;
  logic [1:0]   row_in_en;
  logic [1:0]   row_ps_en;
  logic [W-1:0] array_data;
  logic         busy;
  logic         done;
  logic [2:0]   fsm_state;

  int tests;
  int fails;
  int tile_no;
  bit mon_en;

  // {kind[1:0], row[1:0], data[63:0]}
  logic [W+3:0] exp_q[$];
  logic [W-1:0] last_data;
  logic [1:0]   last_row_in;
  logic [1:0]   last_row_ps;

  systolic_array_load_sequencer #(.N(N), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .reuse_weights  (reuse_weights),
    .src_valid      (src_valid),
    .src_data       (src_data),
    .src_ready      (src_ready),
    .fifo_has_space (fifo_has_space),
    .weight_en      (weight_en),
    .input_en       (input_en),
    .partial_en     (partial_en),
    .row_in_en      (row_in_en),
    .row_ps_en      (row_ps_en),
    .array_data     (array_data),
    .busy           (busy),
    .done           (done),
    .fsm_state      (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every issued beat must match the head of exp_q;
  // between beats the bus must hold its last values.
  always @(negedge clk) begin
    logic [W+3:0] e;
    logic [W+3:0] obs;
    logic [1:0]   kind;
    if (mon_en) begin
      check("onehot_en", 128'($countones({weight_en, input_en, partial_en}) <= 1), 128'(1));
      if (weight_en || input_en || partial_en) begin
        kind = weight_en ? K_W : (input_en ? K_I : K_P);
        obs  = {kind, (partial_en ? row_ps_en : row_in_en), array_data};
        if (exp_q.size() == 0) begin
          check("extra_beat", 128'(obs), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("beat", 128'(obs), 128'(e));
          last_data = e[W-1:0];
          if (e[W+3:W+2] == K_P) last_row_ps = e[W+1:W];
          else                   last_row_in = e[W+1:W];
        end
      end else begin
        check("hold_data", 128'(array_data), 128'(last_data));
        check("hold_rows", 128'({row_in_en, row_ps_en}), 128'({last_row_in, last_row_ps}));
      end
    end
  end

  // Driver: runs one tile. Beat j carries data {tile, j} in every lane.
  //   reuse      : reuse_weights value in the start cycle
  //   toggle_w   : src_valid 1,0,1,0.. during the weight phase
  //   fifo_low_w : fifo_has_space held 0 during the weight phase
  //   stall_len  : cycles of fifo_has_space=0 while P1 is pending
  //   extra_start: pulse start (with reuse_weights=1) mid-tile
  //   abort_idx  : raise rst once this many beats have been accepted (-1 off)
  //   exp_cycles : expected cycles from start to done
  task automatic run_tile(input string tag, input logic reuse,
                          input bit toggle_w, input bit fifo_low_w,
                          input int stall_len, input bit extra_start,
                          input int abort_idx, input int exp_cycles);
    logic [W-1:0] d[12];
    int  n, base, idx, cyc, stall_cnt, k, m;
    bit  tog, acc, seen_done;
    logic [7:0] t8;
`ifdef SEQ_WEIGHT_REUSE_EN
    base = reuse ? N : 0;
`else
    base = 0;
`endif
    n = 3 * N - base;
    tile_no++;
    t8 = 8'(tile_no);
    for (int j = 0; j < 12; j++) d[j] = {4{t8, 8'(j)}};
    for (int j = 0; j < n; j++) begin
      if (abort_idx < 0 || j < abort_idx) begin
        k = j + base;
        if (k < N) begin
          exp_q.push_back({K_W, 2'(k), d[j]});
        end else begin
          m = k - N;
          exp_q.push_back({(m % 2 == 1) ? K_P : K_I, 2'(m / 2), d[j]});
        end
      end
    end
    // start cycle (cycle 0)
    start = 1'b1;
    reuse_weights = reuse;
    src_valid = 1'b0;
    fifo_has_space = 1'b1;
    @(negedge clk);
    check({tag, "_busy_at_start"}, 128'(busy), 128'(0));
    @(posedge clk); #1;
    start = 1'b0;
    reuse_weights = 1'b0;
    idx = 0; cyc = 1; stall_cnt = 0; tog = 1'b1; seen_done = 1'b0;
    while (cyc < 200) begin
      if (abort_idx >= 0 && idx == abort_idx) begin
        rst = 1'b1;
        src_valid = 1'b0;
        return;
      end
      start = (extra_start && cyc == 3);
      reuse_weights = (extra_start && cyc == 3);
      if (idx >= n)                           src_valid = 1'b0;
      else if (toggle_w && idx + base < N)    src_valid = tog;
      else                                    src_valid = 1'b1;
      if (toggle_w && idx + base < N) tog = ~tog;
      src_data = (idx < n) ? d[idx] : '0;
      if (fifo_low_w && idx + base < N)                      fifo_has_space = 1'b0;
      else if (stall_len > 0 && idx == 7 && stall_cnt < stall_len) fifo_has_space = 1'b0;
      else                                                    fifo_has_space = 1'b1;
      @(negedge clk);
      if (cyc == 1) check({tag, "_busy_run"}, 128'(busy), 128'(1));
      if (!fifo_has_space && idx + base >= N) begin
        stall_cnt++;
        check({tag, "_stall_ready"}, 128'(src_ready), 128'(0));
      end
      acc = src_valid && src_ready;
      if (done) begin
        seen_done = 1'b1;
        check({tag, "_done_cycle"}, 128'(cyc), 128'(exp_cycles));
        check({tag, "_beat_count"}, 128'(idx), 128'(n));
        break;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    if (!seen_done) check({tag, "_done_timeout"}, 128'(0), 128'(1));
    start = 1'b0;
    src_valid = 1'b0;
    fifo_has_space = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_done_pulse"}, 128'({done, busy}), 128'(0));
    check({tag, "_back_idle"}, 128'(fsm_state), 128'(0));
    check({tag, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 128'({src_ready, weight_en, input_en, partial_en, busy, done}), 128'(0));
    check({tag, "_rows"}, 128'({row_in_en, row_ps_en}), 128'(0));
    check({tag, "_data"}, 128'(array_data), 128'(0));
    check({tag, "_state"}, 128'(fsm_state), 128'(0));
  endtask

  // Directed sequence
  initial begin
    tests = 0; fails = 0; tile_no = 0; mon_en = 1'b0;
    last_data = '0; last_row_in = '0; last_row_ps = '0;
    rst = 1'b1; start = 1'b0; reuse_weights = 1'b0;
    src_valid = 1'b0; src_data = '0; fifo_has_space = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;  // reset wins over start
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Back-to-back tile: 12 beats, done 13 cycles after start
    run_tile("basic", 1'b0, 1'b0, 1'b0, 0, 1'b0, -1, 13);
    // P1 stalled 5 cycles by the FIFO
    run_tile("stall", 1'b0, 1'b0, 1'b0, 5, 1'b0, -1, 18);
    // src_valid toggling in LOAD_W, fifo low there (must be ignored)
    run_tile("toggle", 1'b0, 1'b1, 1'b1, 0, 1'b0, -1, 16);
    // start pulsed while busy is ignored
    run_tile("busy_start", 1'b0, 1'b0, 1'b0, 0, 1'b1, -1, 13);
`ifdef SEQ_WEIGHT_REUSE_EN
    run_tile("reuse", 1'b1, 1'b0, 1'b0, 0, 1'b0, -1, 9);
`else
    run_tile("reuse_off", 1'b1, 1'b0, 1'b0, 0, 1'b0, -1, 13);
`endif

    // Abort after I2 has been issued
    run_tile("abort", 1'b0, 1'b0, 1'b0, 0, 1'b0, 9, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_data = '0; last_row_in = '0; last_row_ps = '0;
    check("abort_queue", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    @(negedge clk);
    check_all_zero("abort");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_no_done", 128'({done, busy}), 128'(0));
    end
    @(posedge clk); #1;
    run_tile("restart", 1'b0, 1'b0, 1'b0, 0, 1'b0, -1, 13);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
